// File: rtl/mc14500_pkg.sv
// Shared types and constants for the MC14500 program sequencer.
package mc14500_pkg;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_EXEC    = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_HALT    = 2'd3
  } seq_state_e;

  localparam logic [3:0] OP_NOPO = 4'h0;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_RTN  = 4'hD;
  localparam logic [3:0] OP_SKZ  = 4'hE;
  localparam logic [3:0] OP_NOPF = 4'hF;

endpackage

// File: rtl/mc14500_retstack.sv
// Return-address LIFO for subroutine calls; push and pop are mutually exclusive.
module mc14500_retstack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] top_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW:0]   sp_q, sp_d;
  logic [AW-1:0] wr_idx, top_idx;

  assign wr_idx  = sp_q[AW-1:0];
  assign top_idx = wr_idx - AW'(1);
  assign full_o  = (sp_q == (AW+1)'(DEPTH));
  assign empty_o = (sp_q == '0);
  assign top_o   = mem_q[top_idx];

  always_comb begin
    sp_d = sp_q;
    if (push_i && !full_o)
      sp_d = sp_q + (AW+1)'(1);
    else if (pop_i && !empty_o)
      sp_d = sp_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) sp_q <= '0;
    else      sp_q <= sp_d;
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wr_idx] <= data_i;
  end

endmodule

// File: rtl/mc14500_sequencer.sv
// Program sequencer for the MC14500 ICU: fetch, single-step execute, resolve strobes.
//   state      | meaning
//   ST_FETCH   | request program word at pc, wait for mem_ack
//   ST_EXEC    | present opcode/operand, pulse icu_ce
//   ST_RESOLVE | act on ICU strobes: jump, call, return, halt or pc+1
//   ST_HALT    | stopped; run=1 resumes fetch at the held pc
module mc14500_sequencer
  import mc14500_pkg::*;
#(
  parameter int              PC_W        = 8,
  parameter int              STACK_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC    = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic            mem_req,
  output logic [PC_W-1:0] mem_addr,
  input  logic [11:0]     mem_rdata,
  input  logic            mem_ack,
  output logic [3:0]      icu_i,
  output logic            icu_ce,
  input  logic            icu_jmp,
  input  logic            icu_rtn,
  input  logic            icu_flag_o,
  input  logic            icu_flag_f,
  input  logic            icu_write,
  output logic [7:0]      io_addr,
  output logic            io_we,
  output logic            halted,
  output logic            stk_err,
  output logic [PC_W-1:0] pc
);

  seq_state_e      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc, target, stk_top;
  logic [3:0]      op_q, op_d;
  logic [7:0]      operand_q, operand_d;
  logic            err_q, err_d;
  logic            armed_q;
  logic            push, pop, stk_full, stk_empty;

  mc14500_retstack #(.DEPTH(STACK_DEPTH), .W(PC_W)) u_stack (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (pc_inc),
    .full_o  (stk_full),
    .empty_o (stk_empty),
    .top_o   (stk_top)
  );

  assign pc_inc = pc_q + PC_W'(1);
  assign target = operand_q[PC_W-1:0];

  // armed_q holds off the request for one cycle after reset so a late ack is dropped.
  assign mem_req  = (state_q == ST_FETCH) && armed_q;
  assign mem_addr = pc_q;
  assign icu_ce   = (state_q == ST_EXEC);
  assign icu_i    = op_q;
  assign io_addr  = operand_q;
  assign io_we    = (state_q == ST_RESOLVE) && icu_write;
  assign halted   = (state_q == ST_HALT);
  assign stk_err  = err_q;
  assign pc       = pc_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    op_d      = op_q;
    operand_d = operand_q;
    err_d     = err_q;
    push      = 1'b0;
    pop       = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (armed_q && mem_ack) begin
          op_d      = mem_rdata[11:8];
          operand_d = mem_rdata[7:0];
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_RESOLVE;
      ST_RESOLVE: begin
        state_d = ST_FETCH;
        if (icu_jmp) begin
          pc_d = target;
        end else if (icu_flag_o) begin
          if (stk_full) begin
            err_d   = 1'b1;
            state_d = ST_HALT;
          end else begin
            push = 1'b1;
            pc_d = target;
          end
        end else if (icu_rtn) begin
          if (stk_empty) begin
            err_d   = 1'b1;
            state_d = ST_HALT;
          end else begin
            pop  = 1'b1;
            pc_d = stk_top;
          end
        end else if (icu_flag_f) begin
          pc_d    = pc_inc;
          state_d = ST_HALT;
        end else begin
          pc_d = pc_inc;
        end
      end
      ST_HALT: if (run) state_d = ST_FETCH;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      op_q      <= '0;
      operand_q <= '0;
      err_q     <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      op_q      <= op_d;
      operand_q <= operand_d;
      err_q     <= err_d;
      armed_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mc14500_sequencer.sv
// Bench for mc14500_sequencer: program memory + ICU strobe model, fetch-address scoreboard.
module tb_mc14500_sequencer;
  import mc14500_pkg::*;

  localparam int PC_W = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            run = 1'b0;
  logic            mem_req, icu_ce, io_we, halted, stk_err;
  logic [PC_W-1:0] mem_addr, pc;
  logic [11:0]     mem_rdata = '0;
  logic            mem_ack = 1'b0;
  logic [3:0]      icu_i;
  logic            icu_jmp = 1'b0, icu_rtn = 1'b0, icu_flag_o = 1'b0, icu_flag_f = 1'b0;
  logic            icu_write = 1'b0;
  logic [7:0]      io_addr;

  int checks = 0;
  int errors = 0;

  logic [11:0] prog [256];
  logic [7:0]  exp_q [$];
  logic [7:0]  exp_addr;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  bit          inject_ack = 1'b0;
  bit          sb_on = 1'b0;
  bit          skip_jmp = 1'b0;
  bit          ce_prev = 1'b0;
  logic [3:0]  op_prev = '0;

  always #5 clk = ~clk;

  mc14500_sequencer #(.PC_W(PC_W), .STACK_DEPTH(4), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .run(run),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .icu_i(icu_i), .icu_ce(icu_ce),
    .icu_jmp(icu_jmp), .icu_rtn(icu_rtn), .icu_flag_o(icu_flag_o), .icu_flag_f(icu_flag_f),
    .icu_write(icu_write),
    .io_addr(io_addr), .io_we(io_we), .halted(halted), .stk_err(stk_err), .pc(pc)
  );

  // Memory and ICU model, driven 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk); #1;
      icu_jmp = 0; icu_rtn = 0; icu_flag_o = 0; icu_flag_f = 0; icu_write = 0;
      if (ce_prev && !(skip_jmp && op_prev == OP_JMP)) begin
        case (op_prev)
          OP_JMP:     icu_jmp = 1;
          OP_RTN:     icu_rtn = 1;
          OP_NOPO:    icu_flag_o = 1;
          OP_NOPF:    icu_flag_f = 1;
          4'h8, 4'h9: icu_write = 1;
          default: ;
        endcase
      end
      ce_prev = (icu_ce === 1'b1);
      op_prev = icu_i;
      mem_ack = 0;
      if (inject_ack) begin
        mem_ack = 1; mem_rdata = 12'hC77; inject_ack = 0; wait_cnt = 0;
      end else if (mem_req === 1'b1) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack = 1; mem_rdata = prog[mem_addr]; wait_cnt = 0;
          if (sb_on) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL fetch_unexpected addr=%02h required none", mem_addr);
            end else begin
              exp_addr = exp_q.pop_front();
              if (mem_addr !== exp_addr) begin
                errors++;
                $display("FAIL fetch_addr got=%02h required=%02h", mem_addr, exp_addr);
              end
            end
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #3;
  endtask

  task automatic fill(input logic [11:0] w);
    for (int i = 0; i < 256; i++) prog[i] = w;
  endtask

  task automatic do_reset();
    sb_on = 0; rst = 0;
    tick(); tick();
    exp_q.delete();
    rst = 1; sb_on = 1;
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) exp_q.push_back(8'(a));
  endtask

  task automatic wait_halt(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (halted === 1'b1) begin ok = 1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    fill(12'hF00);
    do_reset();
    checks++;
    if ({mem_req, icu_ce, io_we, halted, stk_err} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b required=00000", {mem_req, icu_ce, io_we, halted, stk_err});
    end
    checks++;
    if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc got=%02h required=00", pc); end
    checks++;
    if ({icu_i, io_addr} !== 12'h000) begin
      errors++; $display("FAIL reset_icu got=%03h required=000", {icu_i, io_addr});
    end
  endtask

  task automatic test_basic();
    logic [15:0] ce_mask;
    int we_cnt, we_cyc;
    logic [7:0] we_addr;
    logic [3:0] op5;
    fill(12'hF00);
    prog[0] = 12'h103; prog[1] = 12'h810; prog[2] = 12'hF00;
    do_reset();
    push_range(0, 2);
    ce_mask = '0; we_cnt = 0; we_cyc = -1; we_addr = '0; op5 = '0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (icu_ce === 1'b1) ce_mask[c] = 1'b1;
      if (io_we === 1'b1) begin we_cnt++; we_cyc = c; we_addr = io_addr; end
      if (c == 5) op5 = icu_i;
    end
    checks++;
    if (ce_mask !== 16'h0124) begin errors++; $display("FAIL basic_ce_cycles got=%04h required=0124", ce_mask); end
    checks++;
    if (we_cnt != 1 || we_cyc != 6 || we_addr !== 8'h10) begin
      errors++; $display("FAIL basic_io_we got cnt=%0d cyc=%0d addr=%02h required cnt=1 cyc=6 addr=10", we_cnt, we_cyc, we_addr);
    end
    checks++;
    if (op5 !== 4'h8) begin errors++; $display("FAIL basic_icu_i got=%h required=8", op5); end
    checks++;
    if (halted !== 1'b1 || pc !== 8'h03) begin
      errors++; $display("FAIL basic_halt got halted=%b pc=%02h required halted=1 pc=03", halted, pc);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL basic_fetches left=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_jump();
    bit ok;
    for (int s = 0; s < 2; s++) begin
      fill(12'hF00);
      for (int a = 0; a < 5; a++) prog[a] = 12'h100;
      prog[5] = 12'hC40;
      skip_jmp = (s == 1);
      do_reset();
      push_range(0, 5);
      exp_q.push_back(s == 0 ? 8'h40 : 8'h06);
      wait_halt(80, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL jump_timeout skip=%0d halted=%b required=1", s, halted); end
      checks++;
      if (pc !== (s == 0 ? 8'h41 : 8'h07)) begin
        errors++; $display("FAIL jump_pc skip=%0d got=%02h required=%02h", s, pc, (s == 0 ? 8'h41 : 8'h07));
      end
      checks++;
      if (exp_q.size() != 0 || stk_err !== 1'b0) begin
        errors++; $display("FAIL jump_fetches skip=%0d left=%0d err=%b required 0/0", s, exp_q.size(), stk_err);
      end
    end
    skip_jmp = 0;
  endtask

  task automatic test_call_return();
    bit ok;
    fill(12'h100);
    prog[8'h20] = 12'h080; prog[8'h80] = 12'hD00; prog[8'h21] = 12'hD00;
    do_reset();
    push_range(0, 8'h20);
    exp_q.push_back(8'h80); exp_q.push_back(8'h21);
    wait_halt(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL call_ret_timeout halted=%b required=1", halted); end
    checks++;
    if (pc !== 8'h21 || stk_err !== 1'b1) begin
      errors++; $display("FAIL call_ret_underflow got pc=%02h err=%b required pc=21 err=1", pc, stk_err);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL call_ret_fetches left=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_nested();
    bit ok;
    fill(12'hF00);
    prog[8'h00] = 12'h010; prog[8'h10] = 12'h020; prog[8'h20] = 12'hD00; prog[8'h11] = 12'hD00;
    do_reset();
    exp_q.push_back(8'h00); exp_q.push_back(8'h10); exp_q.push_back(8'h20);
    exp_q.push_back(8'h11); exp_q.push_back(8'h01);
    wait_halt(60, ok);
    checks++;
    if (!ok || pc !== 8'h02 || stk_err !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL nested got ok=%0d pc=%02h err=%b left=%0d required 1/02/0/0", ok, pc, stk_err, exp_q.size());
    end
  endtask

  task automatic test_overflow();
    bit ok;
    fill(12'hF00);
    for (int a = 0; a < 5; a++) prog[a] = 12'(a + 1);
    do_reset();
    push_range(0, 4);
    wait_halt(60, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL overflow_timeout halted=%b required=1", halted); end
    checks++;
    if (stk_err !== 1'b1 || pc !== 8'h04) begin
      errors++; $display("FAIL overflow got err=%b pc=%02h required err=1 pc=04", stk_err, pc);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL overflow_fetches left=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_wait_reset();
    bit ok;
    ack_delay = 3;
    fill(12'hF00);
    prog[0] = 12'h100;
    do_reset();
    push_range(0, 1);
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 8'h00 || icu_ce !== 1'b0) begin
        errors++; $display("FAIL wait_hold c=%0d got req=%b addr=%02h ce=%b required 1/00/0", c, mem_req, mem_addr, icu_ce);
      end
    end
    tick();
    checks++;
    if (icu_ce !== 1'b1) begin errors++; $display("FAIL wait_exec got ce=%b required=1", icu_ce); end
    wait_halt(60, ok);
    checks++;
    if (!ok || pc !== 8'h02 || exp_q.size() != 0) begin
      errors++; $display("FAIL wait_done got ok=%0d pc=%02h left=%0d required 1/02/0", ok, pc, exp_q.size());
    end
    do_reset();
    tick(); tick();
    rst = 0; inject_ack = 1;
    tick();
    checks++;
    if (mem_req !== 1'b0 || pc !== 8'h00 || icu_ce !== 1'b0) begin
      errors++; $display("FAIL midfetch_reset got req=%b pc=%02h ce=%b required 0/00/0", mem_req, pc, icu_ce);
    end
    rst = 1;
    push_range(0, 1);
    wait_halt(60, ok);
    checks++;
    if (!ok || pc !== 8'h02 || stk_err !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL stale_ack got ok=%0d pc=%02h err=%b left=%0d required 1/02/0/0", ok, pc, stk_err, exp_q.size());
    end
    ack_delay = 0;
  endtask

  task automatic test_wrap_resume();
    bit ok;
    fill(12'hF00);
    prog[8'h00] = 12'hCFF; prog[8'hFF] = 12'h050; prog[8'h50] = 12'hD00;
    do_reset();
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h50); exp_q.push_back(8'h00);
    tick(); tick(); tick();
    prog[8'h00] = 12'hF00;
    wait_halt(60, ok);
    checks++;
    if (!ok || pc !== 8'h01 || stk_err !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL wrap got ok=%0d pc=%02h err=%b left=%0d required 1/01/0/0", ok, pc, stk_err, exp_q.size());
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (halted !== 1'b1 || mem_req !== 1'b0 || icu_ce !== 1'b0) begin
        errors++; $display("FAIL halt_idle got halted=%b req=%b ce=%b required 1/0/0", halted, mem_req, icu_ce);
      end
    end
    exp_q.push_back(8'h01);
    run = 1;
    tick();
    run = 0;
    checks++;
    if (halted !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 8'h01) begin
      errors++; $display("FAIL resume got halted=%b req=%b addr=%02h required 0/1/01", halted, mem_req, mem_addr);
    end
    wait_halt(30, ok);
    checks++;
    if (!ok || pc !== 8'h02 || exp_q.size() != 0) begin
      errors++; $display("FAIL resume_done got ok=%0d pc=%02h left=%0d required 1/02/0", ok, pc, exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_jump();
    test_call_return();
    test_nested();
    test_overflow();
    test_wait_reset();
    test_wrap_resume();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc14500_sequencer.md
Name: mc14500_sequencer

Overview:
Program sequencer for the MC14500 ICU. It holds the program counter, fetches 12-bit program words from an external program memory through a req/ack handshake, and presents the opcode and I/O address to the ICU. It advances the ICU one instruction at a time through a clock enable, and resolves the ICU's JMP/RTN/FLAG_O/FLAG_F strobes into PC updates, subroutine calls/returns and halt. It sits beside the ICU wrapper at the top level and turns the bare ICU into a standalone bit-serial controller.

Parameters:
PC_W, 8, program counter / program address width (operand field is 8 bits; the low PC_W bits are used as jump target)
STACK_DEPTH, 4, return-stack entries (power of two, 2..16)
RESET_PC, 0, PC value loaded at reset

Ports:
clk  in  1  system clock; also clocks the ICU
rst  in  1  synchronous, active-low reset
run  in  1  level; leaves HALT when high
mem_req  out  1  program fetch request
mem_addr  out  PC_W  fetch address
mem_rdata  in  12  program word: [11:8] opcode, [7:0] operand
mem_ack  in  1  rdata valid; one-cycle pulse
icu_i  out  4  opcode to ICU I[3:0]
icu_ce  out  1  ICU clock enable; ICU executes exactly one instruction per high cycle
icu_jmp  in  1  ICU JMP strobe
icu_rtn  in  1  ICU RTN strobe
icu_flag_o  in  1  ICU FLAG_O strobe
icu_flag_f  in  1  ICU FLAG_F strobe
icu_write  in  1  ICU WRITE strobe
io_addr  out  8  I/O select = operand of the current instruction
io_we  out  1  icu_write gated to RESOLVE
halted  out  1  state == HALT
stk_err  out  1  sticky stack overflow/underflow
pc  out  PC_W  current PC

Behaviour:
- ICU strobes are registered inside the ICU and are valid in the cycle after icu_ce. Strobes are suppressed by the ICU on skipped instructions (SKZ, post-RTN skip), so the sequencer never decodes opcodes itself.
- Reset (rst=0 at clk edge): state=FETCH, pc=RESET_PC, stack pointer=0, stk_err=0, mem_req=0, icu_ce=0, icu_i=0, io_addr=0, io_we=0, halted=0. A reset mid-fetch drops mem_req on the next cycle; a late mem_ack is ignored.
- States: FETCH, EXEC, RESOLVE, HALT.
- FETCH: mem_req=1, mem_addr=pc. Hold until mem_ack=1, then latch opcode and operand and go to EXEC. Wait length is unbounded.
- EXEC (1 cycle): icu_i=opcode, icu_ce=1, io_addr=operand. Go to RESOLVE.
- RESOLVE (1 cycle): icu_ce=0, icu_i and io_addr hold their values, io_we=icu_write. Evaluate strobes with priority jmp > flag_o > rtn > flag_f:
  - jmp: pc=operand[PC_W-1:0].
  - flag_o (call): if sp==STACK_DEPTH, set stk_err and go to HALT with pc unchanged. Otherwise push pc+1, sp++, pc=operand.
  - rtn: if sp==0, set stk_err and go to HALT. Otherwise sp--, pc=top of stack.
  - flag_f: pc=pc+1, go to HALT.
  - none: pc=pc+1.
  - Next state is FETCH unless HALT was selected.
- HALT: halted=1, mem_req=0, icu_ce=0. If run=1, go to FETCH at the current pc. stk_err is cleared only by reset.
- pc+1 wraps from 2^PC_W-1 to 0. A pushed return address wraps the same way.
- Throughput: 3 cycles per instruction with a zero-wait memory (ack in the first FETCH cycle).
- icu_ce is high for exactly one cycle per fetched word, and never in HALT or FETCH.

Decomposition:
- Shared package mc14500_pkg: the state enum and opcode constants (NOPO=0, JMP=C, RTN=D, SKZ=E, NOPF=F), used by the benches.
- One sub-module, mc14500_retstack: a LIFO of STACK_DEPTH x PC_W with push, pop, full, empty and top; push and pop are never asserted together.

Test Plan:
- Zero-wait memory, program LD(1,0x03), STO(8,0x10), NOPF(F) -> icu_ce pulses at cycles 2, 5, 8; io_we in the RESOLVE of STO with io_addr=0x10; halted=1 with pc=3.
- JMP at 0x05 with operand 0x40 (icu_jmp returned in RESOLVE) -> next mem_addr=0x40. Same word with icu_jmp=0 (skipped) -> next mem_addr=0x06.
- NOPO call at 0x20 with operand 0x80, then RTN at 0x80 -> pushes 0x21; after RTN the next fetch is at 0x21 and sp returns to 0.
- Five nested calls with STACK_DEPTH=4 -> 5th call sets stk_err and halted, pc stays at the 5th call's address. RTN with an empty stack -> stk_err, halted.
- mem_ack delayed 3 cycles, and rst=0 asserted during a pending fetch -> mem_addr held stable while waiting; after reset pc=RESET_PC, mem_req=0 for one cycle, and the stale ack has no effect.
- PC at 0xFF with no strobe -> next fetch at 0x00. In HALT with run=1 -> FETCH resumes at the held pc.
